// File: rtl/cr16_psr_cond.sv
// CR16 processor status register with delayed ALU flag capture, explicit writes
// and a forwarding condition-code evaluator for Bcond/Jcond/Scond.
module cr16_psr_cond #(
  parameter int P_STATUS_WIDTH = 5
) (
  input  logic                      I_CLK,
  input  logic                      I_RESET,
  input  logic                      I_ALU_ENABLE,
  input  logic                      I_STATUS_WE,
  input  logic [P_STATUS_WIDTH-1:0] I_ALU_STATUS,
  input  logic                      I_PSR_WE,
  input  logic [P_STATUS_WIDTH-1:0] I_PSR_DATA,
  input  logic                      I_COND_VALID,
  input  logic [3:0]                I_COND,
  output logic [P_STATUS_WIDTH-1:0] O_PSR,
  output logic                      O_FLAGS_PENDING,
  output logic                      O_COND_VALID,
  output logic                      O_COND_TRUE
);

  localparam int C_BIT = 0;
  localparam int L_BIT = 1;
  localparam int F_BIT = 2;
  localparam int Z_BIT = 3;
  localparam int N_BIT = 4;

  logic [P_STATUS_WIDTH-1:0] psr_q, psr_d;
  logic                      pending_q, pending_d;
  logic                      cond_valid_q;
  logic                      cond_true_q, cond_true_d;
  logic                      c_f, l_f, f_f, z_f, n_f;

  // psr_d is the effective PSR: explicit write beats a pending ALU commit.
  always_comb begin
    psr_d = psr_q;
    if (I_PSR_WE) begin
      psr_d = I_PSR_DATA;
    end else if (pending_q) begin
      psr_d = I_ALU_STATUS;
    end
    pending_d = I_ALU_ENABLE & I_STATUS_WE;
  end

  assign c_f = psr_d[C_BIT];
  assign l_f = psr_d[L_BIT];
  assign f_f = psr_d[F_BIT];
  assign z_f = psr_d[Z_BIT];
  assign n_f = psr_d[N_BIT];

  always_comb begin
    cond_true_d = 1'b0;
    case (I_COND)
      4'd0:    cond_true_d = z_f;
      4'd1:    cond_true_d = ~z_f;
      4'd2:    cond_true_d = c_f;
      4'd3:    cond_true_d = ~c_f;
      4'd4:    cond_true_d = l_f;
      4'd5:    cond_true_d = ~l_f;
      4'd6:    cond_true_d = n_f;
      4'd7:    cond_true_d = ~n_f;
      4'd8:    cond_true_d = f_f;
      4'd9:    cond_true_d = ~f_f;
      4'd10:   cond_true_d = ~l_f & ~z_f;
      4'd11:   cond_true_d = l_f | z_f;
      4'd12:   cond_true_d = ~n_f & ~z_f;
      4'd13:   cond_true_d = n_f | z_f;
      4'd14:   cond_true_d = 1'b1;
      default: cond_true_d = 1'b0;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      psr_q        <= '0;
      pending_q    <= 1'b0;
      cond_valid_q <= 1'b0;
      cond_true_q  <= 1'b0;
    end else begin
      psr_q        <= psr_d;
      pending_q    <= pending_d;
      cond_valid_q <= I_COND_VALID;
      if (I_COND_VALID) begin
        cond_true_q <= cond_true_d;
      end
    end
  end

  assign O_PSR           = psr_q;
  assign O_FLAGS_PENDING = pending_q;
  assign O_COND_VALID    = cond_valid_q;
  assign O_COND_TRUE     = cond_true_q;

endmodule

// File: doc/cr16_psr_cond.md
# cr16_psr_cond

Processor status register and condition evaluator sitting directly downstream of the CR16 ALU. It captures the ALU's 5-bit status output one cycle after each flag-setting ALU operation. It also accepts explicit PSR writes and evaluates the 16 CR16 condition codes for Bcond/Jcond/Scond instructions, forwarding any PSR update that lands on the same edge. The controller uses `O_FLAGS_PENDING` to know when a condition check would see stale flags.

## Interface
Parameters:
- `P_STATUS_WIDTH`, default 5: PSR width. Bit layout is fixed: 0=C (carry), 1=L (low), 2=F (flag/overflow), 3=Z (zero), 4=N (negative).

Ports:
- `I_CLK`, input, 1: sole clock; all state updates on rising edge.
- `I_RESET`, input, 1: synchronous, active-high reset.
- `I_ALU_ENABLE`, input, 1: the same enable the ALU samples this edge.
- `I_STATUS_WE`, input, 1: the ALU op issued this edge updates flags. Meaningful only with `I_ALU_ENABLE`.
- `I_ALU_STATUS`, input, `P_STATUS_WIDTH`: ALU `O_STATUS`. Valid the cycle after the ALU's enabled edge.
- `I_PSR_WE`, input, 1: explicit PSR write (LPR-style).
- `I_PSR_DATA`, input, `P_STATUS_WIDTH`: data for the explicit write.
- `I_COND_VALID`, input, 1: condition evaluation request.
- `I_COND`, input, 4: condition code to evaluate.
- `O_PSR`, output, `P_STATUS_WIDTH`: current PSR.
- `O_FLAGS_PENDING`, output, 1: a flag-setting ALU result has been issued but not yet committed.
- `O_COND_VALID`, output, 1: one-cycle pulse; `O_COND_TRUE` is valid.
- `O_COND_TRUE`, output, 1: condition result.

## Operation
- Two state elements: the PSR register and the `pending` bit (`pending` drives `O_FLAGS_PENDING`). There is no other FSM.
- Issue: on an edge with `I_ALU_ENABLE & I_STATUS_WE`, `pending` is set to 1. Otherwise, on any edge where `pending` = 1, `pending` is cleared to 0.
- Commit: on an edge with `pending` = 1, PSR <= `I_ALU_STATUS`.
- Back-to-back issue: an issue on the same edge as a commit keeps `pending` = 1. The next edge commits the newer status.
- Explicit write: on an edge with `I_PSR_WE`, PSR <= `I_PSR_DATA`.
  - An explicit write overrides a simultaneous commit.
  - The commit is discarded, and `pending` clears unless a new issue occurs on that edge.
- Effective PSR (`eff`) is the value PSR takes at the current edge: `I_PSR_DATA` if `I_PSR_WE`, else `I_ALU_STATUS` if `pending`, else PSR.
- Condition evaluation: on an edge with `I_COND_VALID`, `O_COND_VALID` <= 1 and `O_COND_TRUE` <= f(`I_COND`, `eff`). Otherwise `O_COND_VALID` <= 0 and `O_COND_TRUE` holds its value.
- Condition map:

  | `I_COND` | Name | True when |
  |---|---|---|
  | 0 | EQ | Z |
  | 1 | NE | !Z |
  | 2 | CS | C |
  | 3 | CC | !C |
  | 4 | HI | L |
  | 5 | LS | !L |
  | 6 | GT | N |
  | 7 | LE | !N |
  | 8 | FS | F |
  | 9 | FC | !F |
  | 10 | LO | !L & !Z |
  | 11 | HS | L \| Z |
  | 12 | LT | !N & !Z |
  | 13 | GE | N \| Z |
  | 14 | UC | 1 |
  | 15 | NV | 0 |

- Flag-neutral ALU ops (`I_ALU_ENABLE` = 1, `I_STATUS_WE` = 0) never touch PSR.

## Timing
- Reset: on an edge with `I_RESET` = 1, `O_PSR` = 0, `pending` = 0, `O_COND_VALID` = 0, `O_COND_TRUE` = 0.
  - Reset overrides every simultaneous issue, commit, write, or condition request.
  - An issue in flight when reset asserts is dropped. The first post-reset `I_ALU_STATUS` is ignored unless a new issue occurs.
- ALU-to-PSR latency: issue at edge N, ALU status valid during cycle N..N+1, PSR updated at edge N+1, `O_PSR` visible cycle N+1.
- Explicit-write latency: 1 edge.
- Condition latency: request sampled at edge N, result valid for exactly the cycle after edge N. Continuous `I_COND_VALID` gives one result per cycle.
- Forwarding: a request at the same edge as a commit or explicit write sees the new value. The controller never stalls on `O_FLAGS_PENDING` for correctness, only when it needs the result in the issue cycle itself.
- `O_PSR`, `O_FLAGS_PENDING`, `O_COND_VALID` and `O_COND_TRUE` are registered outputs with no combinational path from inputs.

## Test plan
- Reset: assert `I_RESET` for 2 cycles while driving `I_PSR_WE` = 1 and `I_PSR_DATA` = 5'h1F -> all outputs 0. Deassert -> `O_PSR` = 0.
- Issue/commit: issue at edge N, `I_ALU_STATUS` = 5'b01000 -> `O_FLAGS_PENDING` = 1 in cycle N, `O_PSR` = 5'h08 after N+1. With `I_COND_VALID` and `I_COND` = 0 (EQ) at N+1 -> `O_COND_TRUE` = 1 for one cycle.
- Forwarding and back-to-back issues:
  - Issue at N (status 5'h08) and issue at N+1 (status 5'h10); `I_COND` = 13 (GE) at N+2 -> `O_COND_TRUE` = 1 and `O_PSR` = 5'h10.
  - Repeat with `I_COND` = 0 at N+2 -> `O_COND_TRUE` = 0.
- Write vs commit collision: `pending` = 1 with `I_ALU_STATUS` = 5'h08 while `I_PSR_WE` = 1 and `I_PSR_DATA` = 5'h01 -> `O_PSR` = 5'h01, `O_FLAGS_PENDING` = 0. `I_COND` = 2 -> 1, `I_COND` = 1 -> 1.
- Condition sweep: for each of PSR = 5'h00, 5'h1F, 5'h02 and 5'h08, sweep `I_COND` = 0..15 -> results match the condition map. UC always 1, NV always 0. With PSR = 5'h02, LO = 0 and HS = 1.
- Reset mid-operation: issue at N, `I_RESET` at N+1 with `I_ALU_STATUS` = 5'h1F -> `O_PSR` = 0 and `O_FLAGS_PENDING` = 0 after N+1. `O_PSR` remains 0 at N+2.
